// File: rtl/demorgan_pipe_if.sv
// Operand/result handshake bundle for demorgan_pipe.
// master = operand source / result sink side, slave = the pipeline itself.
interface demorgan_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             inject_fault;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             check_ok;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, a, b, op, inject_fault, out_ready,
        input  in_ready, out_valid, result, check_ok, err_count
    );

    modport slave (
        input  in_valid, a, b, op, inject_fault, out_ready,
        output in_ready, out_valid, result, check_ok, err_count
    );
endinterface

// File: rtl/demorgan_pipe.sv
// Two-stage bitwise logic pipeline. Each word is evaluated in direct gate
// form and in its DeMorgan dual; the two are compared to give a per-word
// self-check flag and a saturating mismatch counter.
module demorgan_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    demorgan_pipe_if.slave  bus
);
    // stage 1: captured operands
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
    logic             r_s1_inj;

    // stage 2: evaluated result
    logic             r_s2_vld;
    logic [WIDTH-1:0] r_result;
    logic             r_ok;
    logic [CNT_W-1:0] r_err;

    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_in_hs;
    logic             w_out_hs;
    logic [WIDTH-1:0] w_direct;
    logic [WIDTH-1:0] w_dual;
    logic [WIDTH-1:0] w_dual_f;

    // S2 takes S1's word whenever it is empty or draining this cycle;
    // in_ready depends only on state and out_ready, never on in_valid.
    assign w_s2_load  = r_s1_vld & (~r_s2_vld | bus.out_ready);
    assign w_in_ready = reset | ~r_s1_vld | w_s2_load;
    assign w_in_hs    = bus.in_valid & w_in_ready;
    assign w_out_hs   = r_s2_vld & bus.out_ready;

    // Both evaluation paths; the dual path is written in DeMorgan form on purpose.
    always_comb begin
        w_direct = '0;
        w_dual   = '0;
        case (r_s1_op)
            3'd0: begin w_direct = r_s1_a & r_s1_b;       w_dual = ~(~r_s1_a | ~r_s1_b); end
            3'd1: begin w_direct = r_s1_a | r_s1_b;       w_dual = ~(~r_s1_a & ~r_s1_b); end
            3'd2: begin w_direct = ~(r_s1_a & r_s1_b);    w_dual = ~r_s1_a | ~r_s1_b;    end
            3'd3: begin w_direct = ~(r_s1_a | r_s1_b);    w_dual = ~r_s1_a & ~r_s1_b;    end
            3'd4: begin w_direct = ~r_s1_a & ~r_s1_b;     w_dual = ~(r_s1_a | r_s1_b);   end
            3'd5: begin w_direct = ~r_s1_a | ~r_s1_b;     w_dual = ~(r_s1_a & r_s1_b);   end
            3'd6: begin w_direct = r_s1_a ^ r_s1_b;       w_dual = (r_s1_a | r_s1_b) & ~(r_s1_a & r_s1_b); end
            default: begin w_direct = ~(r_s1_a ^ r_s1_b); w_dual = (r_s1_a & r_s1_b) | (~r_s1_a & ~r_s1_b); end
        endcase
    end

    // Fault hook flips bit 0 of the dual path only, so check_ok must drop.
    assign w_dual_f = w_dual ^ WIDTH'(r_s1_inj);

    // Stage 1: load on input handshake, empty when it advances with nothing behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_op  <= '0;
            r_s1_inj <= 1'b0;
        end else if (w_in_hs) begin
            r_s1_vld <= 1'b1;
            r_s1_a   <= bus.a;
            r_s1_b   <= bus.b;
            r_s1_op  <= bus.op;
            r_s1_inj <= bus.inject_fault;
        end else if (w_s2_load) begin
            r_s1_vld <= 1'b0;
        end
    end

    // Stage 2: reload from S1 or drain on output handshake; holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_vld <= 1'b0;
            r_result <= '0;
            r_ok     <= 1'b1;
        end else if (w_s2_load) begin
            r_s2_vld <= 1'b1;
            r_result <= w_direct;
            r_ok     <= (w_direct == w_dual_f);
        end else if (w_out_hs) begin
            r_s2_vld <= 1'b0;
        end
    end

    // Mismatch counter: counts delivered bad words, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else if (w_out_hs && !r_ok && (r_err != {CNT_W{1'b1}})) begin
            r_err <= r_err + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_vld;
    assign bus.result    = r_result;
    assign bus.check_ok  = r_ok;
    assign bus.err_count = r_err;
endmodule
